// File: rtl/opcode_decoder_pipe.sv
// Registered opcode decoder with a valid/ready stream, prefix-extended opcode
// space and a saturating illegal-opcode counter.
module opcode_decoder_pipe #(
    parameter int CODE_W      = 5,
    parameter int NUM_OPS     = 6,
    parameter int PREFIX_EN   = 1,
    parameter int PREFIX_CODE = 31,
    parameter int EXT_OPS     = 4,
    parameter int ERR_CNT_W   = 8,
    localparam int OUT_W      = NUM_OPS + EXT_OPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CODE_W-1:0]    code_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_W-1:0]     code_out,
    output logic                 out_illegal,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 prefix_pending,
    input  logic                 err_clear,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] PREFIX = 1'b1;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    logic [0:0]       state;
    logic             accept;
    logic             is_prefix;
    logic [OUT_W-1:0] dec_code;
    logic             dec_illegal;
    logic             err_hit;

    assign in_ready = ~rst & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    assign is_prefix = (PREFIX_EN != 0) && (state == NORMAL)
                       && (code_in == CODE_W'(PREFIX_CODE));

    always_comb begin
        dec_code = '0;
        if (state == NORMAL) begin
            for (int i = 0; i < NUM_OPS; i++)
                dec_code[i] = (code_in == CODE_W'(i));
        end else begin
            for (int k = 0; k < EXT_OPS; k++)
                dec_code[NUM_OPS+k] = (code_in == CODE_W'(k));
        end
    end

    // Decode is one-hot by construction, so "nothing matched" means illegal.
    assign dec_illegal = ~|dec_code;
    assign err_hit     = accept & ~is_prefix & dec_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NORMAL;
            out_valid   <= 1'b0;
            code_out    <= '0;
            out_illegal <= 1'b0;
        end else begin
            if (accept)
                state <= is_prefix ? PREFIX : NORMAL;
            if (accept && !is_prefix) begin
                code_out    <= dec_code;
                out_illegal <= dec_illegal;
                out_valid   <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A clear coinciding with an illegal accept keeps that error.
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (err_clear)
            err_count <= err_hit ? ERR_CNT_W'(1) : '0;
        else if (err_hit && err_count != ERR_MAX)
            err_count <= err_count + 1'b1;
    end

    assign prefix_pending = (state == PREFIX);

endmodule
